// File: rtl/jtbubl_main_sndcom.sv
// Main-CPU side of the main<->sound mailbox: command latch with strobe sequencing,
// sound CPU reset control and reply capture with overrun tracking.
module jtbubl_main_sndcom #(
  parameter int STB_LEN = 4,
  parameter int RST_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic [7:0] snd_latch,
  output logic       snd_stb,
  output logic       snd_rstn,
  input  logic [7:0] main_latch,
  input  logic       main_stb,
  input  logic       snd_flag,
  output logic       main_flag
);

  localparam logic [7:0] STB_INIT = 8'(STB_LEN);
  localparam logic [7:0] RST_INIT = 8'(RST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    STB,
    GAP
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] stb_cnt, stb_cnt_nxt;
  logic [7:0] rst_cnt;
  logic [7:0] main_latch_q;
  logic       wr_q, rd_q, main_stb_q;
  logic       hold, covr, rovr;
  logic       wr_lvl, rd_lvl, wr_ev, rd_ev, reply_ev;
  logic       wr_cmd, wr_clr, wr_ctl, rd_reply;
  logic [7:0] status;

  // Bus strobes may be held for many cycles, so only their rising edges act.
  assign wr_lvl   = cs & cpu_wr;
  assign rd_lvl   = cs & cpu_rd;
  assign wr_ev    = wr_lvl & ~wr_q;
  assign rd_ev    = rd_lvl & ~rd_q;
  assign reply_ev = main_stb & ~main_stb_q;

  assign wr_cmd   = wr_ev & (addr == 2'd0);
  assign wr_clr   = wr_ev & (addr == 2'd1);
  assign wr_ctl   = wr_ev & (addr == 2'd2);
  assign rd_reply = rd_ev & (addr == 2'd0);

  assign status   = {4'b0, rovr, covr, ~snd_flag, main_flag};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      main_stb_q <= 1'b0;
    end else begin
      wr_q       <= wr_lvl;
      rd_q       <= rd_lvl;
      main_stb_q <= main_stb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      stb_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      stb_cnt <= stb_cnt_nxt;
    end
  end

  // A command arriving mid-pulse inserts a one-cycle low gap so the sound side
  // always sees a fresh rising edge; one arriving in the gap just joins it.
  always_comb begin
    state_nxt   = state;
    stb_cnt_nxt = stb_cnt;
    case (state)
      IDLE: begin
        if (wr_cmd) begin
          state_nxt   = STB;
          stb_cnt_nxt = STB_INIT;
        end
      end
      STB: begin
        if (wr_cmd) begin
          state_nxt = GAP;
        end else if (stb_cnt <= 8'd1) begin
          state_nxt   = IDLE;
          stb_cnt_nxt = 8'd0;
        end else begin
          stb_cnt_nxt = stb_cnt - 8'd1;
        end
      end
      GAP: begin
        state_nxt   = STB;
        stb_cnt_nxt = STB_INIT;
      end
      default: begin
        state_nxt   = IDLE;
        stb_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign snd_stb = (state == STB);

  always_ff @(posedge clk) begin
    if (rst) begin
      snd_latch <= 8'd0;
      covr      <= 1'b0;
    end else begin
      if (wr_cmd) snd_latch <= cpu_dout;
      if (wr_cmd && !snd_flag) covr <= 1'b1;
      else if (wr_clr && cpu_dout[2]) covr <= 1'b0;
    end
  end

  // A reply landing on the same edge as a reply read wins: the flag stays set
  // and the read still returns the previously captured byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_latch_q <= 8'd0;
      main_flag    <= 1'b0;
      rovr         <= 1'b0;
    end else begin
      if (reply_ev) begin
        main_latch_q <= main_latch;
        main_flag    <= 1'b1;
      end else if (rd_reply) begin
        main_flag <= 1'b0;
      end
      if (reply_ev && main_flag) rovr <= 1'b1;
      else if (wr_clr && cpu_dout[3]) rovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= 1'b0;
      rst_cnt <= RST_INIT;
    end else begin
      if (wr_ctl) hold <= cpu_dout[0];
      if (wr_ctl && cpu_dout[1]) rst_cnt <= RST_INIT;
      else if (rst_cnt != 8'd0) rst_cnt <= rst_cnt - 8'd1;
    end
  end

  assign snd_rstn = ~hold & (rst_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_din <= 8'hff;
    end else begin
      case (addr)
        2'd0:    cpu_din <= main_latch_q;
        2'd1:    cpu_din <= status;
        2'd2:    cpu_din <= {7'b0, hold};
        default: cpu_din <= 8'hff;
      endcase
    end
  end

endmodule

// File: tb/tb_jtbubl_main_sndcom.sv
// Scoreboard bench for the main-side sound mailbox: stimulus pushes expected reads,
// strobe pulses and reset pulses; a negedge monitor pops and compares them.
module tb_jtbubl_main_sndcom;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       cpu_wr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic [7:0] cpu_dout = 8'd0;
  logic [7:0] cpu_din;
  logic [7:0] snd_latch;
  logic       snd_stb;
  logic       snd_rstn;
  logic [7:0] main_latch = 8'd0;
  logic       main_stb = 1'b0;
  logic       snd_flag = 1'b1;
  logic       main_flag;

  logic       rdCheck = 1'b0;
  logic [7:0] rdQ[$];
  string      rdNameQ[$];
  logic [7:0] latchQ[$];
  int         stbLenQ[$];
  int         rstnLenQ[$];
  int         nChecks = 0;
  int         nFails = 0;

  jtbubl_main_sndcom #(.STB_LEN(4), .RST_LEN(16)) dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .snd_latch(snd_latch), .snd_stb(snd_stb),
    .snd_rstn(snd_rstn), .main_latch(main_latch), .main_stb(main_stb),
    .snd_flag(snd_flag), .main_flag(main_flag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: event with nothing expected at %0t", name, $time);
  endtask

  // Monitor: reads, strobe pulses (latch at rise, width at fall), reset-pulse widths.
  initial begin
    bit prevStb = 0;
    bit prevRstn = 0;
    int stbRun = 0;
    int lowRun = 0;
    forever begin
      @(negedge clk);
      if (rdCheck) begin
        if (rdQ.size() == 0) unexpected("read");
        else checkOutput(rdNameQ.pop_front(), 32'(cpu_din), 32'(rdQ.pop_front()));
      end
      if (snd_stb === 1'b1) begin
        if (!prevStb) begin
          stbRun = 1;
          if (latchQ.size() == 0) unexpected("stb rise");
          else checkOutput("snd_latch at stb rise", 32'(snd_latch), 32'(latchQ.pop_front()));
        end else begin
          stbRun++;
        end
      end else if (prevStb) begin
        if (stbLenQ.size() == 0) unexpected("stb fall");
        else checkOutput("snd_stb width", stbRun, stbLenQ.pop_front());
      end
      prevStb = (snd_stb === 1'b1);
      if (rst) begin
        lowRun = 0;
        prevRstn = 0;
      end else begin
        if (snd_rstn !== 1'b1) begin
          lowRun++;
        end else if (!prevRstn) begin
          if (rstnLenQ.size() == 0) unexpected("rstn rise");
          else checkOutput("snd_rstn low width", lowRun, rstnLenQ.pop_front());
          lowRun = 0;
        end
        prevRstn = (snd_rstn === 1'b1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [7:0] d, input int holdCycles);
    @(posedge clk); #1;
    cs = 1'b1; cpu_wr = 1'b1; addr = a; cpu_dout = d;
    repeat (holdCycles) @(posedge clk);
    #1;
    cs = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, input logic [7:0] exp, input string name);
    rdQ.push_back(exp);
    rdNameQ.push_back(name);
    @(posedge clk); #1;
    cs = 1'b1; cpu_rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; cpu_rd = 1'b0; rdCheck = 1'b1;
    @(negedge clk); #1;
    rdCheck = 1'b0;
  endtask

  task automatic reply(input logic [7:0] d);
    @(posedge clk); #1;
    main_latch = d; main_stb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    main_stb = 1'b0;
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus();
    rstnLenQ.push_back(16);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20);
    readReg(2'd1, 8'h00, "status after reset");
    readReg(2'd3, 8'hff, "addr3 read");
    readReg(2'd2, 8'h00, "hold after reset");

    latchQ.push_back(8'h5A); stbLenQ.push_back(4);
    writeReg(2'd0, 8'h5A, 10);
    idle(6);

    latchQ.push_back(8'h01); stbLenQ.push_back(2);
    latchQ.push_back(8'h02); stbLenQ.push_back(4);
    writeReg(2'd0, 8'h01, 1);
    writeReg(2'd0, 8'h02, 1);
    idle(8);

    snd_flag = 1'b0;
    latchQ.push_back(8'hAA); stbLenQ.push_back(4);
    writeReg(2'd0, 8'hAA, 1);
    readReg(2'd1, 8'h06, "status covr set");
    snd_flag = 1'b1;
    writeReg(2'd1, 8'h04, 1);
    readReg(2'd1, 8'h00, "status covr cleared");
    idle(6);

    reply(8'hC3);
    readReg(2'd1, 8'h01, "status reply pending");
    reply(8'h3C);
    readReg(2'd1, 8'h09, "status rovr set");
    readReg(2'd0, 8'h3C, "reply byte");
    readReg(2'd1, 8'h08, "status flag cleared");
    writeReg(2'd1, 8'h08, 1);
    readReg(2'd1, 8'h00, "status rovr cleared");

    rdQ.push_back(8'h3C);
    rdNameQ.push_back("read during capture");
    @(posedge clk); #1;
    cs = 1'b1; cpu_rd = 1'b1; addr = 2'd0; main_latch = 8'h77; main_stb = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; cpu_rd = 1'b0; main_stb = 1'b0; rdCheck = 1'b1;
    @(negedge clk); #1;
    rdCheck = 1'b0;
    readReg(2'd1, 8'h01, "status capture wins");
    readReg(2'd0, 8'h77, "reply byte new");
    readReg(2'd1, 8'h00, "status after new read");

    rstnLenQ.push_back(23);
    writeReg(2'd2, 8'h01, 1);
    readReg(2'd2, 8'h01, "hold set");
    idle(3);
    writeReg(2'd2, 8'h02, 1);
    readReg(2'd2, 8'h00, "hold released");
    idle(25);

    latchQ.push_back(8'h11); stbLenQ.push_back(3);
    rstnLenQ.push_back(16);
    writeReg(2'd0, 8'h11, 1);
    idle(1);
    applyReset();
    readReg(2'd1, 8'h00, "status after mid reset");
  endtask

  initial begin
    int budget;
    applyStimulus();
    budget = 0;
    while ((latchQ.size() + stbLenQ.size() + rstnLenQ.size() + rdQ.size()) != 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("pending stb rises", latchQ.size(), 0);
    checkOutput("pending stb widths", stbLenQ.size(), 0);
    checkOutput("pending rstn pulses", rstnLenQ.size(), 0);
    checkOutput("pending reads", rdQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
